fixed_convert: RTL and testbench

Arithmetic support block for the CORDIC datapath. It converts IEEE-754 single-precision floats to signed Q(INTEGER_WIDTH).(FRACTIONAL_WIDTH) fixed point and back. It also provides the fixed-point adder/subtractor used by the CORDIC rotation steps. Both converters are independent, equal-latency, clock-enabled pipelines; the adder/subtractor is combinational.

---
 rtl/fixed_convert_if.sv | 31 +++
 rtl/fixed_convert.sv | 161 ++++++++++++++++
 tb/tb_fixed_convert.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fixed_convert_if.sv
// Bundle of the fixed_convert converter and adder signals.
// master: the CORDIC datapath that drives operands and consumes results.
// slave:  the fixed_convert block itself.
interface fixed_convert_if #(
    parameter int W = 24
) ();
    logic         clk_en;
    logic         f2x_valid_in;
    logic [31:0]  flt_in;
    logic         f2x_valid_out;
    logic [W-1:0] fix_out;
    logic         x2f_valid_in;
    logic [W-1:0] fix_in;
    logic         x2f_valid_out;
    logic [31:0]  flt_out;
    logic [W-1:0] as_a;
    logic [W-1:0] as_b;
    logic         as_add;
    logic [W-1:0] as_result;
    logic         as_ovf;

    modport master (
        output clk_en, f2x_valid_in, flt_in, x2f_valid_in, fix_in, as_a, as_b, as_add,
        input  f2x_valid_out, fix_out, x2f_valid_out, flt_out, as_result, as_ovf
    );

    modport slave (
        input  clk_en, f2x_valid_in, flt_in, x2f_valid_in, fix_in, as_a, as_b, as_add,
        output f2x_valid_out, fix_out, x2f_valid_out, flt_out, as_result, as_ovf
    );
endinterface

// File: rtl/fixed_convert.sv
// Float <-> signed Q(INTEGER_WIDTH).(FRACTIONAL_WIDTH) conversion pipelines and
// the combinational fixed-point adder/subtractor for the CORDIC datapath.
// Both converters: stage A decodes, stage B rounds/normalizes, then LATENCY-2
// plain delay stages. LATENCY must be at least 2; fixed-to-float is exact for W <= 24.
// Optional feature: define SAT_ADDSUB_EN to saturate as_result on overflow
// (default build wraps modulo 2^W).
module fixed_convert #(
    parameter int INTEGER_WIDTH    = 4,
    parameter int FRACTIONAL_WIDTH = 20,
    parameter int LATENCY          = 3
) (
    input logic           clk,
    input logic           rst,
    fixed_convert_if.slave bus
);
    localparam int W     = INTEGER_WIDTH + FRACTIONAL_WIDTH;
    localparam int DEPTH = LATENCY - 1;
    // Biased exponent at which |value| >= 2^(INTEGER_WIDTH-1): always saturates.
    localparam logic [7:0] EXP_SAT = 8'(127 + INTEGER_WIDTH - 1);
    // Shift that turns the 24-bit mantissa into value * 2^(FRACTIONAL_WIDTH+1).
    localparam int SH_BIAS = 149 - FRACTIONAL_WIDTH;
    localparam logic [W-1:0] FIX_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] FIX_MIN = {1'b1, {(W-1){1'b0}}};

    // float -> fixed, stage A: magnitude carries one extra fractional bit for rounding
    logic              f2x_a_valid_d, f2x_a_valid_q;
    logic              f2x_a_sign_d,  f2x_a_sign_q;
    logic              f2x_a_sat_d,   f2x_a_sat_q;
    logic [W-1:0]      f2x_a_mag_d,   f2x_a_mag_q;
    logic [7:0]        f2x_exp;
    logic signed [31:0] f2x_sh;
    logic [W+23:0]     f2x_mant;
    logic [W-1:0]      f2x_rnd;
    logic              f2x_sat;
    logic [W-1:0]      f2x_data_d [DEPTH];
    logic [W-1:0]      f2x_data_q [DEPTH];
    logic [DEPTH-1:0]  f2x_vld_d,  f2x_vld_q;

    // fixed -> float, stage A: sign and magnitude (most negative code maps to 2^(W-1))
    logic              x2f_a_valid_d, x2f_a_valid_q;
    logic              x2f_a_sign_d,  x2f_a_sign_q;
    logic [W-1:0]      x2f_a_mag_d,   x2f_a_mag_q;
    logic [7:0]        x2f_lod;
    logic [22:0]       x2f_frac;
    logic [31:0]       x2f_data_d [DEPTH];
    logic [31:0]       x2f_data_q [DEPTH];
    logic [DEPTH-1:0]  x2f_vld_d,  x2f_vld_q;

    logic [W:0]        as_sum;

    // Decode the float: class it, and align its mantissa to the fixed grid (plus a half bit).
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave a latch.
        f2x_a_valid_d = bus.f2x_valid_in;
        f2x_a_sign_d  = bus.flt_in[31];
        f2x_a_sat_d   = 1'b0;
        f2x_a_mag_d   = '0;
        f2x_exp       = bus.flt_in[30:23];
        f2x_sh        = $signed({24'd0, f2x_exp}) - SH_BIAS;
        f2x_mant      = {{W{1'b0}}, 1'b1, bus.flt_in[22:0]};
        if (f2x_exp == 8'hFF) begin
            // Inf saturates; NaN keeps magnitude 0 and converts to 0.
            f2x_a_sat_d = (bus.flt_in[22:0] == 23'd0);
        end else if (f2x_exp >= EXP_SAT) begin
            f2x_a_sat_d = 1'b1;
        end else if (f2x_exp != 8'h00) begin
            // Denormals and zero stay 0; normals shift, truncating below the half bit.
            if (f2x_sh >= 0) f2x_a_mag_d = W'(f2x_mant << f2x_sh);
            else             f2x_a_mag_d = W'(f2x_mant >> (-f2x_sh));
        end
    end

    // Round half away from zero, saturate, apply sign; feed the delay line.
    always_comb begin
        f2x_rnd = W'(({1'b0, f2x_a_mag_q} + (W+1)'(1)) >> 1);
        f2x_sat = f2x_a_sat_q | f2x_rnd[W-1];
        if (f2x_sat)           f2x_data_d[0] = f2x_a_sign_q ? FIX_MIN : FIX_MAX;
        else if (f2x_a_sign_q) f2x_data_d[0] = -f2x_rnd;
        else                   f2x_data_d[0] = f2x_rnd;
        f2x_vld_d[0] = f2x_a_valid_q;
        for (int i = 1; i < DEPTH; i++) begin
            f2x_data_d[i] = f2x_data_q[i-1];
            f2x_vld_d[i]  = f2x_vld_q[i-1];
        end
    end

    // Split the fixed operand into sign and magnitude.
    always_comb begin
        x2f_a_valid_d = bus.x2f_valid_in;
        x2f_a_sign_d  = bus.fix_in[W-1];
        x2f_a_mag_d   = bus.fix_in[W-1] ? -bus.fix_in : bus.fix_in;
    end

    // Leading-one detect, normalize and pack the float; feed the delay line.
    always_comb begin
        x2f_lod = '0;
        for (int i = 0; i < W; i++) begin
            if (x2f_a_mag_q[i]) x2f_lod = 8'(i);
        end
        // Move the leading one to bit 23 and drop it (hidden bit).
        x2f_frac = 23'(24'(x2f_a_mag_q) << (23 - int'(x2f_lod)));
        if (x2f_a_mag_q == '0) x2f_data_d[0] = 32'd0;
        else x2f_data_d[0] = {x2f_a_sign_q, 8'(127 - FRACTIONAL_WIDTH + int'(x2f_lod)), x2f_frac};
        x2f_vld_d[0] = x2f_a_valid_q;
        for (int i = 1; i < DEPTH; i++) begin
            x2f_data_d[i] = x2f_data_q[i-1];
            x2f_vld_d[i]  = x2f_vld_q[i-1];
        end
    end

    // Signed add/subtract with an extra sign bit to detect overflow of the true result.
    always_comb begin
        as_sum = bus.as_add ? {bus.as_a[W-1], bus.as_a} + {bus.as_b[W-1], bus.as_b}
                            : {bus.as_a[W-1], bus.as_a} - {bus.as_b[W-1], bus.as_b};
        bus.as_ovf    = as_sum[W] ^ as_sum[W-1];
        bus.as_result = as_sum[W-1:0];
`ifdef SAT_ADDSUB_EN
        if (bus.as_ovf) bus.as_result = as_sum[W] ? FIX_MIN : FIX_MAX;
`endif
    end

    // Pipeline registers: reset clears all, clk_en low holds all.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            f2x_a_valid_q <= 1'b0;
            f2x_a_sign_q  <= 1'b0;
            f2x_a_sat_q   <= 1'b0;
            f2x_a_mag_q   <= '0;
            x2f_a_valid_q <= 1'b0;
            x2f_a_sign_q  <= 1'b0;
            x2f_a_mag_q   <= '0;
            f2x_vld_q     <= '0;
            x2f_vld_q     <= '0;
            // NOTE: data stages are reset too, since the outputs must read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                f2x_data_q[i] <= '0;
                x2f_data_q[i] <= '0;
            end
        end else if (bus.clk_en) begin
            f2x_a_valid_q <= f2x_a_valid_d;
            f2x_a_sign_q  <= f2x_a_sign_d;
            f2x_a_sat_q   <= f2x_a_sat_d;
            f2x_a_mag_q   <= f2x_a_mag_d;
            x2f_a_valid_q <= x2f_a_valid_d;
            x2f_a_sign_q  <= x2f_a_sign_d;
            x2f_a_mag_q   <= x2f_a_mag_d;
            f2x_vld_q     <= f2x_vld_d;
            x2f_vld_q     <= x2f_vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                f2x_data_q[i] <= f2x_data_d[i];
                x2f_data_q[i] <= x2f_data_d[i];
            end
        end
    end

    assign bus.fix_out       = f2x_data_q[DEPTH-1];
    assign bus.f2x_valid_out = f2x_vld_q[DEPTH-1];
    assign bus.flt_out       = x2f_data_q[DEPTH-1];
    assign bus.x2f_valid_out = x2f_vld_q[DEPTH-1];
endmodule

// File: tb/tb_fixed_convert.sv
// Directed-vector bench for fixed_convert: conversions, latency, stall, reset, add/sub.
module tb_fixed_convert;
    localparam int W  = 24;
    localparam int NF = 14;
    localparam int NX = 8;
    localparam int NA = 6;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    fixed_convert_if #(.W(W)) bus_if ();

    fixed_convert #(
        .INTEGER_WIDTH(4),
        .FRACTIONAL_WIDTH(20),
        .LATENCY(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // float in -> expected fixed out
    logic [31:0] f2x_in  [NF] = '{32'h3F800000, 32'h3F490FDB, 32'hBF000000, 32'h41200000,
                                  32'hC1200000, 32'h7FC00000, 32'h00000001, 32'h7F800000,
                                  32'hFF800000, 32'h35000000, 32'h34FFFFFF, 32'h40FFFFFF,
                                  32'hC1000000, 32'h80000000};
    logic [31:0] f2x_exp [NF] = '{32'h100000, 32'h0C90FE, 32'hF80000, 32'h7FFFFF,
                                  32'h800000, 32'h000000, 32'h000000, 32'h7FFFFF,
                                  32'h800000, 32'h000001, 32'h000000, 32'h7FFFFF,
                                  32'h800000, 32'h000000};
    // fixed in -> expected float out
    logic [W-1:0] x2f_in  [NX] = '{24'h100000, 24'hF80000, 24'h000000, 24'h800000,
                                   24'h0C90FE, 24'h7FFFFF, 24'h000001, 24'hFFFFFF};
    logic [31:0]  x2f_exp [NX] = '{32'h3F800000, 32'hBF000000, 32'h00000000, 32'hC1000000,
                                   32'h3F490FE0, 32'h40FFFFFE, 32'h35800000, 32'hB5800000};
    // add/sub: a, b, add, expected wrapped result, expected saturated result, expected ovf
    logic [W-1:0] as_a_v  [NA] = '{24'h100000, 24'h100000, 24'h7FFFFF, 24'h800000, 24'h800000, 24'h000000};
    logic [W-1:0] as_b_v  [NA] = '{24'h080000, 24'h180000, 24'h000001, 24'h000001, 24'h800000, 24'h800000};
    logic         as_op_v [NA] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] as_wrap [NA] = '{24'h180000, 24'hF80000, 24'h800000, 24'h7FFFFF, 24'h000000, 24'h800000};
    logic [W-1:0] as_sat  [NA] = '{24'h180000, 24'hF80000, 24'h7FFFFF, 24'h800000, 24'h800000, 24'h7FFFFF};
    logic         as_ovf_v[NA] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                 = 1'b1;
        bus_if.clk_en       = 1'b1;
        bus_if.f2x_valid_in = 1'b0;
        bus_if.flt_in       = '0;
        bus_if.x2f_valid_in = 1'b0;
        bus_if.fix_in       = '0;
        bus_if.as_a         = '0;
        bus_if.as_b         = '0;
        bus_if.as_add       = 1'b1;
        step();
        step();
        check("rst_fix_out", 32'(bus_if.fix_out), 32'h0);
        check("rst_flt_out", bus_if.flt_out, 32'h0);
        check("rst_f2x_vld", 32'(bus_if.f2x_valid_out), 32'h0);
        check("rst_x2f_vld", 32'(bus_if.x2f_valid_out), 32'h0);
        rst = 1'b0;

        // One vector at a time through both converters; result exactly 3 edges later.
        for (int i = 0; i < NF; i++) begin
            bus_if.f2x_valid_in = 1'b1;
            bus_if.flt_in       = f2x_in[i];
            bus_if.x2f_valid_in = (i < NX);
            bus_if.fix_in       = (i < NX) ? x2f_in[i] : '0;
            step();
            bus_if.f2x_valid_in = 1'b0;
            bus_if.x2f_valid_in = 1'b0;
            step();
            check($sformatf("f2x_early_vld[%0d]", i), 32'(bus_if.f2x_valid_out), 32'h0);
            check($sformatf("x2f_early_vld[%0d]", i), 32'(bus_if.x2f_valid_out), 32'h0);
            step();
            check($sformatf("f2x_vld[%0d]", i), 32'(bus_if.f2x_valid_out), 32'h1);
            check($sformatf("f2x[%0d]", i), 32'(bus_if.fix_out), f2x_exp[i]);
            if (i < NX) begin
                check($sformatf("x2f_vld[%0d]", i), 32'(bus_if.x2f_valid_out), 32'h1);
                check($sformatf("x2f[%0d]", i), bus_if.flt_out, x2f_exp[i]);
            end
        end

        // Stall: two items in flight, clk_en low for 2 cycles, then hold an output.
        bus_if.f2x_valid_in = 1'b1;
        bus_if.flt_in       = 32'h3F800000;
        step();
        bus_if.flt_in       = 32'hBF000000;
        step();
        bus_if.clk_en       = 1'b0;
        bus_if.flt_in       = 32'h41200000;
        step();
        check("stall_vld0", 32'(bus_if.f2x_valid_out), 32'h0);
        step();
        check("stall_vld1", 32'(bus_if.f2x_valid_out), 32'h0);
        bus_if.clk_en       = 1'b1;
        bus_if.f2x_valid_in = 1'b0;
        step();
        check("stall_a_vld", 32'(bus_if.f2x_valid_out), 32'h1);
        check("stall_a", 32'(bus_if.fix_out), 32'h100000);
        bus_if.clk_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("hold_vld[%0d]", k), 32'(bus_if.f2x_valid_out), 32'h1);
            check($sformatf("hold_data[%0d]", k), 32'(bus_if.fix_out), 32'h100000);
        end
        bus_if.clk_en = 1'b1;
        step();
        check("stall_b_vld", 32'(bus_if.f2x_valid_out), 32'h1);
        check("stall_b", 32'(bus_if.fix_out), 32'hF80000);
        step();
        check("stall_drain_vld", 32'(bus_if.f2x_valid_out), 32'h0);

        // Reset with two items in flight in each converter, clk_en low (rst wins).
        bus_if.f2x_valid_in = 1'b1;
        bus_if.x2f_valid_in = 1'b1;
        bus_if.flt_in       = 32'h3F800000;
        bus_if.fix_in       = 24'h100000;
        step();
        bus_if.flt_in       = 32'hBF000000;
        bus_if.fix_in       = 24'hF80000;
        step();
        bus_if.f2x_valid_in = 1'b0;
        bus_if.x2f_valid_in = 1'b0;
        bus_if.clk_en       = 1'b0;
        rst                 = 1'b1;
        step();
        check("mid_rst_fix", 32'(bus_if.fix_out), 32'h0);
        check("mid_rst_flt", bus_if.flt_out, 32'h0);
        check("mid_rst_f2x_vld", 32'(bus_if.f2x_valid_out), 32'h0);
        check("mid_rst_x2f_vld", 32'(bus_if.x2f_valid_out), 32'h0);
        rst           = 1'b0;
        bus_if.clk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post_rst_f2x_vld[%0d]", k), 32'(bus_if.f2x_valid_out), 32'h0);
            check($sformatf("post_rst_x2f_vld[%0d]", k), 32'(bus_if.x2f_valid_out), 32'h0);
        end
        bus_if.f2x_valid_in = 1'b1;
        bus_if.flt_in       = 32'hBF000000;
        step();
        bus_if.f2x_valid_in = 1'b0;
        step();
        check("first_new_early", 32'(bus_if.f2x_valid_out), 32'h0);
        step();
        check("first_new_vld", 32'(bus_if.f2x_valid_out), 32'h1);
        check("first_new", 32'(bus_if.fix_out), 32'hF80000);

        // Combinational add/sub.
        for (int i = 0; i < NA; i++) begin
            bus_if.as_a   = as_a_v[i];
            bus_if.as_b   = as_b_v[i];
            bus_if.as_add = as_op_v[i];
            #1;
`ifdef SAT_ADDSUB_EN
            check($sformatf("as_result[%0d]", i), 32'(bus_if.as_result), 32'(as_sat[i]));
`else
            check($sformatf("as_result[%0d]", i), 32'(bus_if.as_result), 32'(as_wrap[i]));
`endif
            check($sformatf("as_ovf[%0d]", i), 32'(bus_if.as_ovf), 32'(as_ovf_v[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
